// File: rtl/tc_pkg.sv
// Shared definitions for the bridge-mapped down-counting timer.
// State encoding, register word indices, CTRL bit positions and mode codes.
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CNT,
        INT
    } tc_state_e;

    localparam logic [1:0] IDX_CTRL   = 2'd0;
    localparam logic [1:0] IDX_PRESET = 2'd1;
    localparam logic [1:0] IDX_COUNT  = 2'd2;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// Programmable 32-bit down-counting timer with one-shot and auto-reload modes.
// Drives a level interrupt (masked by CTRL.IM) towards the exception unit.
module timer_counter
    import tc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    tc_state_e   state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        en;
    logic [1:0]  mode;
    logic [1:0]  idx;
    logic        unused_addr;

    assign en          = ctrl_q[CTRL_EN];
    assign mode        = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
    assign idx         = addr[3:2];
    assign unused_addr = ^{addr[31:4], addr[1:0]};

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        // FSM always acts on the pre-write CTRL value.
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = INT;
                end
            end
            INT: begin
                if (mode == MODE_AUTO) begin
                    irq_flag_d = 1'b0;
                    state_d    = LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus writes override the FSM's CTRL/flag updates in the same cycle.
        if (we) begin
            case (idx)
                IDX_CTRL: begin
                    ctrl_d     = wdata[3:0];
                    irq_flag_d = 1'b0;
                end
                IDX_PRESET: preset_d = wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            IDX_CTRL:   rdata = {28'd0, ctrl_q};
            IDX_PRESET: rdata = preset_q;
            IDX_COUNT:  rdata = count_q;
            default:    rdata = '0;
        endcase
    end

    assign irq = ctrl_q[CTRL_IM] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter.
// Inputs change on the falling edge; outputs are sampled just after rising edges.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int compared;
    int mismatched;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_PRESET = 32'h4;
    localparam logic [31:0] A_COUNT  = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;

    // Returns 1 time unit after the rising edge that performs the write.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(32'(i * 4), v);
            compared++;
            if (v !== 32'd0) begin
                mismatched++;
                $display("FAIL reset_rdata[%0d] got %h want 0", i, v);
            end
        end
        compared++;
        if (irq !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_irq got %b want 0", irq);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] v;
        bus_write(A_PRESET, 32'd5);
        bus_write(A_CTRL, 32'h9);
        tick(2);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd5) begin mismatched++; $display("FAIL os_count_t2 got %0d want 5", v); end
        tick(1);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd4) begin mismatched++; $display("FAIL os_count_t3 got %0d want 4", v); end
        tick(3);
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("FAIL os_irq_t6 got %b want 0", irq); end
        tick(1);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd0) begin mismatched++; $display("FAIL os_count_t7 got %0d want 0", v); end
        compared++;
        if (irq !== 1'b1) begin mismatched++; $display("FAIL os_irq_t7 got %b want 1", irq); end
        tick(1);
        rd(A_CTRL, v);
        compared++;
        if (v !== 32'h8) begin mismatched++; $display("FAIL os_ctrl_t8 got %h want 8", v); end
        tick(2);
        compared++;
        if (irq !== 1'b1) begin mismatched++; $display("FAIL os_irq_held got %b want 1", irq); end
        bus_write(A_CTRL, 32'h8);
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("FAIL os_irq_clr got %b want 0", irq); end
    endtask

    task automatic test_auto_reload();
        logic [31:0] v;
        bus_write(A_PRESET, 32'd3);
        bus_write(A_CTRL, 32'hB);
        tick(2);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd3) begin mismatched++; $display("FAIL ar_count_t2 got %0d want 3", v); end
        tick(2);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd1) begin mismatched++; $display("FAIL ar_count_t4 got %0d want 1", v); end
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("FAIL ar_irq_t4 got %b want 0", irq); end
        tick(1);
        compared++;
        if (irq !== 1'b1) begin mismatched++; $display("FAIL ar_irq_t5 got %b want 1", irq); end
        tick(1);
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("FAIL ar_irq_t6 got %b want 0", irq); end
        rd(A_CTRL, v);
        compared++;
        if (v !== 32'hB) begin mismatched++; $display("FAIL ar_ctrl_t6 got %h want b", v); end
        tick(1);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd3) begin mismatched++; $display("FAIL ar_count_t7 got %0d want 3", v); end
        tick(2);
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("FAIL ar_irq_t9 got %b want 0", irq); end
        tick(1);
        compared++;
        if (irq !== 1'b1) begin mismatched++; $display("FAIL ar_irq_t10 got %b want 1", irq); end
        tick(1);
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("FAIL ar_irq_t11 got %b want 0", irq); end
        bus_write(A_CTRL, 32'h8);
        tick(2);
    endtask

    task automatic test_disable();
        logic [31:0] v;
        bus_write(A_PRESET, 32'd10);
        bus_write(A_CTRL, 32'h9);
        tick(6);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd6) begin mismatched++; $display("FAIL dis_count_t6 got %0d want 6", v); end
        bus_write(A_CTRL, 32'h8);
        tick(3);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd5) begin mismatched++; $display("FAIL dis_count_frozen got %0d want 5", v); end
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("FAIL dis_irq got %b want 0", irq); end
        bus_write(A_CTRL, 32'h9);
        tick(1);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd5) begin mismatched++; $display("FAIL dis_count_load got %0d want 5", v); end
        tick(1);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd10) begin mismatched++; $display("FAIL dis_count_reload got %0d want 10", v); end
        bus_write(A_CTRL, 32'h8);
        tick(2);
    endtask

    task automatic test_small_preset(input logic [31:0] n);
        logic [31:0] v;
        bus_write(A_PRESET, n);
        bus_write(A_CTRL, 32'h9);
        tick(2);
        rd(A_COUNT, v);
        compared++;
        if (v !== n) begin mismatched++; $display("FAIL sp%0d_count_t2 got %0d want %0d", n, v, n); end
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("FAIL sp%0d_irq_t2 got %b want 0", n, irq); end
        tick(1);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd0) begin mismatched++; $display("FAIL sp%0d_count_t3 got %0d want 0", n, v); end
        compared++;
        if (irq !== 1'b1) begin mismatched++; $display("FAIL sp%0d_irq_t3 got %b want 1", n, irq); end
        bus_write(A_CTRL, 32'h8);
        tick(2);
    endtask

    task automatic test_preset_during_cnt();
        logic [31:0] v;
        bus_write(A_PRESET, 32'd4);
        bus_write(A_CTRL, 32'hB);
        tick(2);
        bus_write(A_PRESET, 32'd2);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd3) begin mismatched++; $display("FAIL pc_count_t3 got %0d want 3", v); end
        tick(3);
        compared++;
        if (irq !== 1'b1) begin mismatched++; $display("FAIL pc_irq_t6 got %b want 1", irq); end
        tick(2);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd2) begin mismatched++; $display("FAIL pc_count_t8 got %0d want 2", v); end
        bus_write(A_CTRL, 32'h8);
        tick(1);
        bus_write(A_COUNT, 32'hDEAD_BEEF);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd1) begin mismatched++; $display("FAIL ro_count got %h want 1", v); end
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        rd(A_RSVD, v);
        compared++;
        if (v !== 32'd0) begin mismatched++; $display("FAIL rsvd_read got %h want 0", v); end
        rd(A_CTRL, v);
        compared++;
        if (v !== 32'h8) begin mismatched++; $display("FAIL rsvd_ctrl got %h want 8", v); end
        rd(A_PRESET, v);
        compared++;
        if (v !== 32'd2) begin mismatched++; $display("FAIL rsvd_preset got %0d want 2", v); end
        bus_write(A_CTRL, 32'hFFFF_FFF0);
        rd(A_CTRL, v);
        compared++;
        if (v !== 32'h0) begin mismatched++; $display("FAIL ctrl_upper got %h want 0", v); end
        tick(1);
    endtask

    task automatic test_collision();
        logic [31:0] v;
        bus_write(A_PRESET, 32'd2);
        bus_write(A_CTRL, 32'h9);
        tick(4);
        compared++;
        if (irq !== 1'b1) begin mismatched++; $display("FAIL col_irq_t4 got %b want 1", irq); end
        bus_write(A_CTRL, 32'h9);
        rd(A_CTRL, v);
        compared++;
        if (v !== 32'h9) begin mismatched++; $display("FAIL col_ctrl got %h want 9", v); end
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("FAIL col_irq_clr got %b want 0", irq); end
        tick(2);
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd2) begin mismatched++; $display("FAIL col_reload got %0d want 2", v); end
        tick(2);
        compared++;
        if (irq !== 1'b1) begin mismatched++; $display("FAIL col_irq_again got %b want 1", irq); end
        bus_write(A_CTRL, 32'h0);
        tick(2);
    endtask

    task automatic test_reset_mid_count();
        logic [31:0] v;
        bus_write(A_PRESET, 32'd3);
        bus_write(A_CTRL, 32'h9);
        tick(3);
        @(negedge clk);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rd(A_COUNT, v);
        compared++;
        if (v !== 32'd0) begin mismatched++; $display("FAIL rst_mid_count got %0d want 0", v); end
        rd(A_CTRL, v);
        compared++;
        if (v !== 32'd0) begin mismatched++; $display("FAIL rst_mid_ctrl got %h want 0", v); end
        tick(6);
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("FAIL rst_mid_irq got %b want 0", irq); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_disable();
        test_small_preset(32'd0);
        test_small_preset(32'd1);
        test_preset_during_cnt();
        test_collision();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
